// File: rtl/washer_pkg.sv
// Shared types and constants for the wash-cycle sequencer: state codes, error
// and motor-speed encodings, phase duration lookups and the soak length.
package washer_pkg;

  typedef enum logic [3:0] {
    ST_OFF    = 4'd0,
    ST_IDLE   = 4'd1,
    ST_DELAY  = 4'd2,
    ST_FILL   = 4'd3,
    ST_SOAK   = 4'd4,
    ST_WASH   = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_RFILL  = 4'd7,
    ST_RINSE  = 4'd8,
    ST_RDRAIN = 4'd9,
    ST_SPIN   = 4'd10,
    ST_DONE   = 4'd11,
    ST_PAUSED = 4'd12,
    ST_ERROR  = 4'd13
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LID     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_UNBAL   = 2'b11;

  localparam logic [1:0] MS_AGITATE   = 2'b00;
  localparam logic [1:0] MS_SPIN_LOW  = 2'b01;
  localparam logic [1:0] MS_SPIN_MED  = 2'b10;
  localparam logic [1:0] MS_SPIN_HIGH = 2'b11;

  localparam int SOAK_TIME = 10;

  function automatic logic [7:0] wash_time(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'd5;
      2'b01:   return 8'd10;
      2'b10:   return 8'd15;
      default: return 8'd8;
    endcase
  endfunction

  function automatic logic [7:0] spin_time(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'd3;
      2'b01:   return 8'd5;
      default: return 8'd7;
    endcase
  endfunction

  function automatic logic [1:0] spin_motor_code(input logic [1:0] sel);
    case (sel)
      2'b00:   return MS_SPIN_LOW;
      2'b01:   return MS_SPIN_MED;
      default: return MS_SPIN_HIGH;
    endcase
  endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// Loadable down-counter for timed phases; saturates at zero, holds while
// frozen, and flags expiry when it reads 1 (the last cycle of a phase).
module washer_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_freeze,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (!i_freeze && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/washer_cycle_sequencer.sv
// Wash-cycle controller: power, delayed start, fill/wash/drain, N rinses, spin,
// done, with pause, lid/timeout/balance errors. Define SOAK_EN to add a soak phase.
module washer_cycle_sequencer
  import washer_pkg::*;
#(
  parameter int TIMER_W      = 8,
  parameter int DELAY_W      = 12,
  parameter int RC_W         = 2,
  parameter int RINSE_TIME   = 6,
  parameter int FILL_TIMEOUT = 200,
  parameter int DONE_HOLD    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               power_button,
  input  logic               start_button,
  input  logic               pause_button,
  input  logic [1:0]         cycle_select,
  input  logic [1:0]         spin_speed_select,
  input  logic [RC_W-1:0]    rinse_count,
  input  logic [DELAY_W-1:0] delay_value,
  input  logic               lid_closed,
  input  logic               water_full,
  input  logic               water_empty,
  input  logic               load_balanced,
  output logic               motor_on,
  output logic [1:0]         motor_speed,
  output logic               fill_valve_on,
  output logic               drain_pump_on,
  output logic               door_locked,
  output logic               power_led,
  output logic               alarm,
  output logic               end_of_cycle_alarm,
  output logic [TIMER_W-1:0] timer,
  output logic [3:0]         state_code,
  output logic [1:0]         error_code
);

  localparam int TO_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FILL_TIMEOUT - 1);

  state_t              r_state, w_state_next, r_ret_state, w_ret_next;
  logic [1:0]          r_err_code, w_err_next, r_cyc_sel, r_spin_sel;
  logic [RC_W-1:0]     r_rinse_left, w_rinse_next;
  logic [DELAY_W-1:0]  r_dly_cnt, w_dly_next;
  logic [TO_W-1:0]     r_to_cnt, w_to_next;
  logic                w_latch, w_go_spin, w_tmr_load, w_tmr_freeze, w_tmr_expire;
  logic [TIMER_W-1:0]  w_tmr_value, w_tmr_count;
  logic                w_active, w_pausable, w_in_fd, w_exit_sensor;
  logic                r_motor_on, r_fill, r_drain, r_door, r_power_led, r_alarm, r_eoc;
  logic [1:0]          r_motor_speed;

  assign w_in_fd       = r_state inside {ST_FILL, ST_RFILL, ST_DRAIN, ST_RDRAIN};
  assign w_exit_sensor = (r_state inside {ST_FILL, ST_RFILL}) ? water_full : water_empty;
  assign w_pausable    = r_state inside {ST_FILL, ST_SOAK, ST_WASH, ST_DRAIN, ST_RFILL,
                                         ST_RINSE, ST_RDRAIN, ST_SPIN};
  assign w_active      = w_pausable || r_state == ST_DELAY || r_state == ST_PAUSED;
  assign w_tmr_freeze  = (r_state == ST_PAUSED) || (w_state_next == ST_PAUSED);

  washer_phase_timer #(.W(TIMER_W)) u_phase_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_tmr_load),
    .i_load_value (w_tmr_value),
    .i_freeze     (w_tmr_freeze),
    .o_count      (w_tmr_count),
    .o_expire     (w_tmr_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret_state;
    w_err_next   = r_err_code;
    w_latch      = 1'b0;
    w_rinse_next = r_rinse_left;
    w_dly_next   = r_dly_cnt;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    w_go_spin    = 1'b0;
    // Event priority: lid open, then fill/drain timeout, then pause, then the phase's own exit.
    if (w_active && !lid_closed) begin
      w_state_next = ST_ERROR;
      w_err_next   = ERR_LID;
    end else if (w_in_fd && !w_exit_sensor && r_to_cnt == TO_LAST) begin
      w_state_next = ST_ERROR;
      w_err_next   = ERR_TIMEOUT;
    end else if (w_pausable && pause_button) begin
      w_state_next = ST_PAUSED;
      w_ret_next   = r_state;
    end else begin
      case (r_state)
        ST_OFF: if (power_button) w_state_next = ST_IDLE;
        ST_IDLE: begin
          if (power_button) begin
            w_state_next = ST_OFF;
          end else if (start_button) begin
            if (!lid_closed) begin
              w_state_next = ST_ERROR;
              w_err_next   = ERR_LID;
            end else begin
              w_latch      = 1'b1;
              w_rinse_next = rinse_count;
              if (delay_value != '0) begin
                w_state_next = ST_DELAY;
                w_dly_next   = delay_value;
              end else begin
                w_state_next = ST_FILL;
              end
            end
          end
        end
        ST_DELAY: begin
          if (start_button)                    w_state_next = ST_IDLE;
          else if (r_dly_cnt <= DELAY_W'(1))   w_state_next = ST_FILL;
          else                                 w_dly_next   = r_dly_cnt - 1'b1;
        end
        ST_FILL: begin
          if (water_full) begin
`ifdef SOAK_EN
            w_state_next = ST_SOAK;
            w_tmr_load   = 1'b1;
            w_tmr_value  = TIMER_W'(SOAK_TIME);
`else
            w_state_next = ST_WASH;
            w_tmr_load   = 1'b1;
            w_tmr_value  = TIMER_W'(wash_time(r_cyc_sel));
`endif
          end
        end
`ifdef SOAK_EN
        ST_SOAK: begin
          if (w_tmr_expire) begin
            w_state_next = ST_WASH;
            w_tmr_load   = 1'b1;
            w_tmr_value  = TIMER_W'(wash_time(r_cyc_sel));
          end
        end
`endif
        ST_WASH: if (w_tmr_expire) w_state_next = ST_DRAIN;
        ST_DRAIN, ST_RDRAIN: begin
          if (water_empty) begin
            if (r_rinse_left != '0) w_state_next = ST_RFILL;
            else                    w_go_spin    = 1'b1;
          end
        end
        ST_RFILL: begin
          if (water_full) begin
            w_state_next = ST_RINSE;
            w_tmr_load   = 1'b1;
            w_tmr_value  = TIMER_W'(RINSE_TIME);
          end
        end
        ST_RINSE: begin
          if (w_tmr_expire) begin
            w_state_next = ST_RDRAIN;
            w_rinse_next = r_rinse_left - 1'b1;
          end
        end
        ST_SPIN: begin
          if (w_tmr_expire) begin
            w_state_next = ST_DONE;
            w_dly_next   = DELAY_W'(DONE_HOLD);
          end
        end
        ST_DONE: begin
          if (power_button)                    w_state_next = ST_OFF;
          else if (r_dly_cnt <= DELAY_W'(1))   w_state_next = ST_IDLE;
          else                                 w_dly_next   = r_dly_cnt - 1'b1;
        end
        ST_PAUSED: if (start_button) w_state_next = r_ret_state;
        ST_ERROR: begin
          if (power_button) begin
            w_state_next = ST_OFF;
            w_err_next   = ERR_NONE;
          end else if (start_button && lid_closed) begin
            w_state_next = ST_IDLE;
            w_err_next   = ERR_NONE;
          end
        end
        default: w_state_next = ST_OFF;
      endcase
    end
    // Balance is sampled only on the edge that would enter SPIN.
    if (w_go_spin) begin
      if (!load_balanced) begin
        w_state_next = ST_ERROR;
        w_err_next   = ERR_UNBAL;
      end else begin
        w_state_next = ST_SPIN;
        w_tmr_load   = 1'b1;
        w_tmr_value  = TIMER_W'(spin_time(r_spin_sel));
      end
    end
    if (w_state_next == ST_ERROR) begin
      w_tmr_load  = 1'b1;
      w_tmr_value = '0;
    end
  end

  // Timeout count survives a pause; any other phase change restarts it.
  always_comb begin
    if (r_state == ST_PAUSED)
      w_to_next = r_to_cnt;
    else if (w_in_fd && (w_state_next == r_state || w_state_next == ST_PAUSED))
      w_to_next = r_to_cnt + 1'b1;
    else
      w_to_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_OFF;
      r_ret_state   <= ST_OFF;
      r_err_code    <= ERR_NONE;
      r_cyc_sel     <= '0;
      r_spin_sel    <= '0;
      r_rinse_left  <= '0;
      r_dly_cnt     <= '0;
      r_to_cnt      <= '0;
      r_motor_on    <= 1'b0;
      r_motor_speed <= MS_AGITATE;
      r_fill        <= 1'b0;
      r_drain       <= 1'b0;
      r_door        <= 1'b0;
      r_power_led   <= 1'b0;
      r_alarm       <= 1'b0;
      r_eoc         <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ret_state  <= w_ret_next;
      r_err_code   <= w_err_next;
      r_rinse_left <= w_rinse_next;
      r_dly_cnt    <= w_dly_next;
      r_to_cnt     <= w_to_next;
      if (w_latch) begin
        r_cyc_sel  <= cycle_select;
        r_spin_sel <= spin_speed_select;
      end
      r_motor_on    <= w_state_next inside {ST_WASH, ST_RINSE, ST_SPIN};
      r_motor_speed <= (w_state_next == ST_SPIN) ? spin_motor_code(r_spin_sel) : MS_AGITATE;
      r_fill        <= w_state_next inside {ST_FILL, ST_RFILL};
      r_drain       <= w_state_next inside {ST_DRAIN, ST_RDRAIN};
      r_door        <= !(w_state_next inside {ST_OFF, ST_IDLE, ST_DONE, ST_ERROR});
      r_power_led   <= (w_state_next != ST_OFF);
      r_alarm       <= (w_state_next == ST_ERROR);
      r_eoc         <= (w_state_next == ST_DONE);
    end
  end

  assign motor_on           = r_motor_on;
  assign motor_speed        = r_motor_speed;
  assign fill_valve_on      = r_fill;
  assign drain_pump_on      = r_drain;
  assign door_locked        = r_door;
  assign power_led          = r_power_led;
  assign alarm              = r_alarm;
  assign end_of_cycle_alarm = r_eoc;
  assign timer              = w_tmr_count;
  assign state_code         = r_state;
  assign error_code         = r_err_code;

endmodule

// File: tb/tb_washer_cycle_sequencer.sv
// Randomised bench: expected behaviour is a timeline of phase segments built
// from the cycle rules; the DUT is compared against it on every clock cycle.
module tb_washer_cycle_sequencer;
  import washer_pkg::*;

  typedef enum int {EV_NONE, EV_FULL, EV_EMPTY, EV_UNBAL, EV_PAUSE, EV_START,
                    EV_START_LIDOPEN, EV_POWER, EV_LID_PAUSE} ev_t;

  typedef struct {
    state_t st;
    int     len;
    int     t0;
    bit     tdec;
    ev_t    ev;
    int     err;
  } seg_t;

  logic        clk, reset_n;
  logic        power_button, start_button, pause_button;
  logic [1:0]  cycle_select, spin_speed_select;
  logic [1:0]  rinse_count;
  logic [11:0] delay_value;
  logic        lid_closed, water_full, water_empty, load_balanced;
  logic        motor_on, fill_valve_on, drain_pump_on, door_locked;
  logic        power_led, alarm, end_of_cycle_alarm;
  logic [1:0]  motor_speed, error_code;
  logic [7:0]  timer;
  logic [3:0]  state_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  seg_t seg_q[$];
  int   m_cs, m_ss, m_rc, m_dly;
  int   wash_tab[4] = '{5, 10, 15, 8};
  int   spin_tab[4] = '{3, 5, 7, 7};

  washer_cycle_sequencer dut (
    .clk(clk), .reset_n(reset_n), .power_button(power_button),
    .start_button(start_button), .pause_button(pause_button),
    .cycle_select(cycle_select), .spin_speed_select(spin_speed_select),
    .rinse_count(rinse_count), .delay_value(delay_value),
    .lid_closed(lid_closed), .water_full(water_full), .water_empty(water_empty),
    .load_balanced(load_balanced), .motor_on(motor_on), .motor_speed(motor_speed),
    .fill_valve_on(fill_valve_on), .drain_pump_on(drain_pump_on),
    .door_locked(door_locked), .power_led(power_led), .alarm(alarm),
    .end_of_cycle_alarm(end_of_cycle_alarm), .timer(timer),
    .state_code(state_code), .error_code(error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void add(state_t st, int len, int t0, bit tdec, ev_t ev, int err);
    seg_t s;
    s.st = st; s.len = len; s.t0 = t0; s.tdec = tdec; s.ev = ev; s.err = err;
    seg_q.push_back(s);
  endfunction

  // Packed view of every indicator/actuator output a given state should show.
  function automatic logic [31:0] exp_outputs(state_t st, int err);
    logic [10:0] v;
    logic [1:0]  spd;
    spd = 2'd0;
    if (st == ST_SPIN) spd = (m_ss == 0) ? 2'd1 : (m_ss == 1) ? 2'd2 : 2'd3;
    v = {(st == ST_WASH || st == ST_RINSE || st == ST_SPIN), spd,
         (st == ST_FILL || st == ST_RFILL), (st == ST_DRAIN || st == ST_RDRAIN),
         !(st == ST_OFF || st == ST_IDLE || st == ST_DONE || st == ST_ERROR),
         (st != ST_OFF), (st == ST_ERROR), (st == ST_DONE), 2'(err)};
    return 32'(v);
  endfunction

  function automatic logic [31:0] obs_outputs();
    return 32'({motor_on, motor_speed, fill_valve_on, drain_pump_on, door_locked,
                power_led, alarm, end_of_cycle_alarm, error_code});
  endfunction

  task automatic drive(input seg_t s, input bit last);
    power_button      = 1'b0;
    start_button      = 1'b0;
    pause_button      = 1'b0;
    lid_closed        = 1'b1;
    cycle_select      = 2'($urandom);
    spin_speed_select = 2'($urandom);
    rinse_count       = 2'($urandom);
    delay_value       = 12'($urandom);
    load_balanced     = 1'($urandom);
    water_full        = (s.st inside {ST_FILL, ST_RFILL})   ? 1'b0 : 1'($urandom);
    water_empty       = (s.st inside {ST_DRAIN, ST_RDRAIN}) ? 1'b0 : 1'($urandom);
    if (s.st inside {ST_DELAY, ST_FILL, ST_WASH, ST_DRAIN, ST_RFILL, ST_RINSE,
                     ST_RDRAIN, ST_SPIN, ST_PAUSED})
      power_button = ($urandom % 6 == 0);
    if (s.st inside {ST_OFF, ST_IDLE, ST_DELAY, ST_DONE, ST_ERROR})
      pause_button = ($urandom % 4 == 0);
    if (last) begin
      case (s.ev)
        EV_FULL:  water_full = 1'b1;
        EV_EMPTY: begin water_empty = 1'b1; load_balanced = 1'b1; end
        EV_UNBAL: begin water_empty = 1'b1; load_balanced = 1'b0; end
        EV_PAUSE: pause_button = 1'b1;
        EV_START, EV_START_LIDOPEN: begin
          start_button = 1'b1;
          power_button = 1'b0;
          lid_closed   = (s.ev == EV_START);
          if (s.st == ST_IDLE) begin
            cycle_select      = 2'(m_cs);
            spin_speed_select = 2'(m_ss);
            rinse_count       = 2'(m_rc);
            delay_value       = 12'(m_dly);
          end
        end
        EV_POWER: power_button = 1'b1;
        EV_LID_PAUSE: begin lid_closed = 1'b0; pause_button = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic run_q();
    seg_t s;
    while (seg_q.size() > 0) begin
      s = seg_q.pop_front();
      for (int k = 0; k < s.len; k++) begin
        check_eq($sformatf("%s[%0d] state", s.st.name(), k), 32'(state_code), 32'(s.st));
        check_eq($sformatf("%s[%0d] timer", s.st.name(), k), 32'(timer),
                 32'(s.tdec ? s.t0 - k : s.t0));
        check_eq($sformatf("%s[%0d] outputs", s.st.name(), k), obs_outputs(),
                 exp_outputs(s.st, s.err));
        drive(s, k == s.len - 1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic set_cfg(input int cs, input int ss, input int rc, input int dly);
    m_cs = cs; m_ss = ss; m_rc = rc; m_dly = dly;
  endtask

  // Queue a complete, uneventful wash with random sensor response times.
  task automatic build_run(input int cs, input int ss, input int rc, input int dly);
    set_cfg(cs, ss, rc, dly);
    $display("wash run: cycle=%0d spin=%0d rinses=%0d delay=%0d", cs, ss, rc, dly);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    if (dly > 0) add(ST_DELAY, dly, 0, 0, EV_NONE, 0);
    add(ST_FILL, $urandom_range(1, 8), 0, 0, EV_FULL, 0);
    add(ST_WASH, wash_tab[cs], wash_tab[cs], 1, EV_NONE, 0);
    add(ST_DRAIN, $urandom_range(1, 8), 0, 0, EV_EMPTY, 0);
    for (int r = 0; r < rc; r++) begin
      add(ST_RFILL, $urandom_range(1, 8), 0, 0, EV_FULL, 0);
      add(ST_RINSE, 6, 6, 1, EV_NONE, 0);
      add(ST_RDRAIN, $urandom_range(1, 8), 0, 0, EV_EMPTY, 0);
    end
    add(ST_SPIN, spin_tab[ss], spin_tab[ss], 1, EV_NONE, 0);
    add(ST_DONE, 4, 0, 0, EV_NONE, 0);
    add(ST_IDLE, 1, 0, 0, EV_NONE, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    power_button = 1'b0; start_button = 1'b0; pause_button = 1'b0;
    cycle_select = '0; spin_speed_select = '0; rinse_count = '0; delay_value = '0;
    lid_closed = 1'b1; water_full = 1'b0; water_empty = 1'b0; load_balanced = 1'b1;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset state", 32'(state_code), 32'(ST_OFF));
    check_eq("reset timer", 32'(timer), 32'd0);
    check_eq("reset outputs", obs_outputs(), 32'd0);
    reset_n = 1'b1;

    add(ST_OFF, 2, 0, 0, EV_POWER, 0);
    add(ST_IDLE, 2, 0, 0, EV_NONE, 0);
    run_q();

    build_run(0, 0, 1, 0);  run_q();
    build_run(1, 2, 0, 20); run_q();

    $display("delay cancel: delay=20, second start after 6 cycles");
    set_cfg(2, 1, 1, 20);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_DELAY, 6, 0, 0, EV_START, 0);
    add(ST_IDLE, 2, 0, 0, EV_NONE, 0);
    run_q();

    $display("pause: WASH paused at timer 7 for 30 cycles");
    set_cfg(1, 0, 0, 0);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_FILL, 3, 0, 0, EV_FULL, 0);
    add(ST_WASH, 4, 10, 1, EV_PAUSE, 0);
    add(ST_PAUSED, 30, 7, 0, EV_START, 0);
    add(ST_WASH, 7, 7, 1, EV_NONE, 0);
    add(ST_DRAIN, 2, 0, 0, EV_EMPTY, 0);
    add(ST_SPIN, 3, 3, 1, EV_NONE, 0);
    add(ST_DONE, 4, 0, 0, EV_NONE, 0);
    add(ST_IDLE, 1, 0, 0, EV_NONE, 0);
    run_q();

    for (int r = 0; r < 6; r++) begin
      build_run(int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                ($urandom % 2 == 1) ? int'($urandom_range(1, 25)) : 0);
      run_q();
    end

    $display("fill timeout: 200 FILL cycles split by a pause");
    set_cfg(0, 0, 0, 0);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_FILL, 5, 0, 0, EV_PAUSE, 0);
    add(ST_PAUSED, 50, 0, 0, EV_START, 0);
    add(ST_FILL, 195, 0, 0, EV_NONE, 0);
    add(ST_ERROR, 3, 0, 0, EV_START, 2);
    add(ST_IDLE, 2, 0, 0, EV_NONE, 0);
    run_q();

    $display("lid open at start, then clear attempts");
    add(ST_IDLE, 1, 0, 0, EV_START_LIDOPEN, 0);
    add(ST_ERROR, 2, 0, 0, EV_START_LIDOPEN, 1);
    add(ST_ERROR, 2, 0, 0, EV_START, 1);
    add(ST_IDLE, 1, 0, 0, EV_NONE, 0);
    run_q();

    $display("lid open coincident with pause in SPIN");
    set_cfg(2, 1, 0, 0);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_FILL, 2, 0, 0, EV_FULL, 0);
    add(ST_WASH, 15, 15, 1, EV_NONE, 0);
    add(ST_DRAIN, 3, 0, 0, EV_EMPTY, 0);
    add(ST_SPIN, 2, 5, 1, EV_LID_PAUSE, 0);
    add(ST_ERROR, 2, 0, 0, EV_START, 1);
    add(ST_IDLE, 1, 0, 0, EV_NONE, 0);
    run_q();

    $display("unbalanced load at SPIN entry");
    set_cfg(3, 2, 1, 0);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_FILL, 1, 0, 0, EV_FULL, 0);
    add(ST_WASH, 8, 8, 1, EV_NONE, 0);
    add(ST_DRAIN, 2, 0, 0, EV_EMPTY, 0);
    add(ST_RFILL, 2, 0, 0, EV_FULL, 0);
    add(ST_RINSE, 6, 6, 1, EV_NONE, 0);
    add(ST_RDRAIN, 3, 0, 0, EV_UNBAL, 0);
    add(ST_ERROR, 2, 0, 0, EV_POWER, 3);
    add(ST_OFF, 2, 0, 0, EV_POWER, 0);
    add(ST_IDLE, 1, 0, 0, EV_NONE, 0);
    run_q();

    $display("asynchronous reset mid-RINSE");
    set_cfg(0, 0, 2, 0);
    add(ST_IDLE, 1, 0, 0, EV_START, 0);
    add(ST_FILL, 1, 0, 0, EV_FULL, 0);
    add(ST_WASH, 5, 5, 1, EV_NONE, 0);
    add(ST_DRAIN, 1, 0, 0, EV_EMPTY, 0);
    add(ST_RFILL, 1, 0, 0, EV_FULL, 0);
    add(ST_RINSE, 3, 6, 1, EV_NONE, 0);
    run_q();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async reset state", 32'(state_code), 32'(ST_OFF));
    check_eq("async reset timer", 32'(timer), 32'd0);
    check_eq("async reset outputs", obs_outputs(), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    add(ST_OFF, 1, 0, 0, EV_POWER, 0);
    add(ST_IDLE, 2, 0, 0, EV_NONE, 0);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
